// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
//   Shared types and constants for the Horner-rule sequencer that drives the
//   external MAC unit.
//   Contents:
//     state_t          - sequencer FSM states
//     MAC_MODE_TRI     - MAC mode select value (fixed)
//     MUL_SRC_IN1/FB   - multiplier source select: external operand / feedback
//     ADD_SRC_EXT      - adder source select: external addend (fixed)
//     COEF_W, ACC_W    - coefficient and accumulator widths
//     NUM_COEF, IDX_W  - coefficient file depth and index width
//     horner_add_idx() - addend coefficient index for a given degree and step
// -----------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam logic MAC_MODE_TRI = 1'b1;
  localparam logic MUL_SRC_IN1  = 1'b0;
  localparam logic MUL_SRC_FB   = 1'b1;
  localparam logic ADD_SRC_EXT  = 1'b0;

  localparam int COEF_W   = 8;
  localparam int ACC_W    = 16;
  localparam int NUM_COEF = 8;
  localparam int IDX_W    = 3;

  // Step k of Horner's rule for degree d adds coefficient c[d-1-k].
  // Only meaningful for k <= d-1; other combinations are never issued.
  function automatic logic [IDX_W-1:0] horner_add_idx(
    input logic [IDX_W-1:0] d,
    input logic [IDX_W-1:0] k
  );
    return d - IDX_W'(1) - k;
  endfunction

endpackage

// File: rtl/mac_coef_rf.sv
// -----------------------------------------------------------------------------
// mac_coef_rf
//   8 x 8-bit polynomial coefficient register file, cleared by reset.
//   Ports:
//     clk, reset             - clock, asynchronous active-high reset
//     wr_en/wr_addr/wr_data  - single synchronous write port
//     rd_addr_a/rd_data_a    - combinational read port (addend coefficient)
//     rd_addr_b/rd_data_b    - combinational read port (leading coefficient,
//                              also c[0] for a degree-0 evaluation)
// -----------------------------------------------------------------------------
module mac_coef_rf
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr_a,
  output logic [COEF_W-1:0] rd_data_a,
  input  logic [IDX_W-1:0]  rd_addr_b,
  output logic [COEF_W-1:0] rd_data_b
);

  logic [COEF_W-1:0] mem [NUM_COEF];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/mac_horner_seq.sv
// -----------------------------------------------------------------------------
// mac_horner_seq
//   Evaluates p(x) = sum c[i] x^i (degree 0..7, mod 2^16) by Horner's rule,
//   sequencing an external MAC unit one step per issue and feeding back the
//   MAC's own result. The result is returned through a valid/ready handshake.
//   Parameter:
//     MAC_LAT      - MAC issue-to-mac_output latency in cycles (>= 1)
//   Ports:
//     clk, reset                      - clock, asynchronous active-high reset
//     coef_wr/coef_addr/coef_data     - coefficient write (dropped while busy)
//     start/degree/x_in               - begin evaluation of degree d at x
//     busy                            - evaluation in progress
//     done                            - one-cycle pulse when result loads
//     result/result_valid/result_ready- result handshake
//     mac_in_1/mac_in_2/mac_in_add    - MAC operands
//     mac_mode                        - MAC mode (fixed)
//     mac_mul_input_mux               - 0: in_1, 1: feedback
//     mac_adder_input_mux             - adder source (fixed external)
//     mac_mul_en/mac_adder_en         - MAC stage enables
//     mac_output                      - MAC result
// -----------------------------------------------------------------------------
module mac_horner_seq
  import mac_pkg::*;
#(
  parameter int MAC_LAT = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_wr,
  input  logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              start,
  input  logic [IDX_W-1:0]  degree,
  input  logic [COEF_W-1:0] x_in,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [COEF_W-1:0] mac_in_1,
  output logic [COEF_W-1:0] mac_in_2,
  output logic [COEF_W-1:0] mac_in_add,
  output logic              mac_mode,
  output logic              mac_mul_input_mux,
  output logic              mac_adder_input_mux,
  output logic              mac_mul_en,
  output logic              mac_adder_en,
  input  logic [ACC_W-1:0]  mac_output
);

  // The wait counter loads MAC_LAT-1 and counts down to 1.
  localparam int WCNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t            state;
  logic [IDX_W-1:0]  deg_q;
  logic [IDX_W-1:0]  step_q;
  logic [COEF_W-1:0] x_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [ACC_W-1:0]  result_q;

  logic [COEF_W-1:0] coef_add;
  logic [COEF_W-1:0] coef_lead;
  logic              last_step;

  // Coefficient writes are only accepted while idle so an evaluation always
  // sees a stable polynomial; a write coincident with start still lands
  // before the first issue.
  mac_coef_rf u_coef_rf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (coef_wr & ~busy_q),
    .wr_addr   (coef_addr),
    .wr_data   (coef_data),
    .rd_addr_a (horner_add_idx(deg_q, step_q)),
    .rd_data_a (coef_add),
    .rd_addr_b (deg_q),
    .rd_data_b (coef_lead)
  );

  assign last_step = (step_q == (deg_q - IDX_W'(1)));

  // Sequencer FSM: IDLE -> (ISSUE [-> WAIT])* -> CAPTURE -> HOLD -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      deg_q    <= '0;
      step_q   <= '0;
      x_q      <= '0;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            deg_q  <= degree;
            x_q    <= x_in;
            step_q <= '0;
            busy_q <= 1'b1;
            state  <= (degree == '0) ? ST_CAPTURE : ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (MAC_LAT > 1) begin
            wait_cnt <= WCNT_W'(MAC_LAT - 1);
            state    <= ST_WAIT;
          end else if (last_step) begin
            state <= ST_CAPTURE;
          end else begin
            step_q <= step_q + IDX_W'(1);
          end
        end

        ST_WAIT: begin
          if (wait_cnt == WCNT_W'(1)) begin
            if (last_step) begin
              state <= ST_CAPTURE;
            end else begin
              step_q <= step_q + IDX_W'(1);
              state  <= ST_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt - WCNT_W'(1);
          end
        end

        ST_CAPTURE: begin
          // Degree 0 never touches the MAC: p(x) is simply c[0], which is
          // what the leading-coefficient port reads when deg_q is 0.
          result_q <= (deg_q == '0) ? {{(ACC_W-COEF_W){1'b0}}, coef_lead}
                                    : mac_output;
          done_q   <= 1'b1;
          valid_q  <= 1'b1;
          state    <= ST_HOLD;
        end

        ST_HOLD: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // MAC drive: decoded from registered state; quiet outside ISSUE.
  // Step 0 multiplies c[d] by x; later steps multiply the fed-back
  // accumulator by x, so in_1 is unused there and held at 0.
  always_comb begin
    mac_in_1          = '0;
    mac_in_2          = '0;
    mac_in_add        = '0;
    mac_mul_input_mux = MUL_SRC_IN1;
    mac_mul_en        = 1'b0;
    mac_adder_en      = 1'b0;
    if (state == ST_ISSUE) begin
      mac_mul_en   = 1'b1;
      mac_adder_en = 1'b1;
      mac_in_2     = x_q;
      mac_in_add   = coef_add;
      if (step_q == '0) begin
        mac_in_1 = coef_lead;
      end else begin
        mac_mul_input_mux = MUL_SRC_FB;
      end
    end
  end

  assign mac_mode            = MAC_MODE_TRI;
  assign mac_adder_input_mux = ADD_SRC_EXT;

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule

// File: doc/mac_horner_seq.md
# mac_horner_seq

Upstream sequencer for `MAC_mac_unit`. It stores up to eight 8-bit polynomial coefficients and a point `x`, then evaluates p(x) by Horner's rule. To do this it drives the MAC unit's operand, mux and enable inputs one step at a time and feeds back the MAC's own result. The final 16-bit value is returned to the system through a valid/ready handshake.

## Interface
Parameters:
- `MAC_LAT`, default 1: MAC issue-to-`mac_output` latency in cycles (≥1).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `coef_wr`  in  1: coefficient write strobe.
- `coef_addr`  in  3: coefficient index (`c[0]` = constant term).
- `coef_data`  in  8: coefficient value.
- `start`  in  1: begin an evaluation.
- `degree`  in  3: polynomial degree, 0..7.
- `x_in`  in  8: evaluation point.
- `busy`  out  1: high from an accepted `start` until the result handshake completes.
- `done`  out  1: one-cycle pulse when `result` is loaded.
- `result`  out  16: p(x) mod 2^16.
- `result_valid`  out  1: result available.
- `result_ready`  in  1: consumer accepts the result.
- `mac_in_1`, `mac_in_2`, `mac_in_add`  out  8 each: MAC operands.
- `mac_mode`  out  1: MAC mode select.
- `mac_mul_input_mux`, `mac_adder_input_mux`  out  1 each: MAC input mux selects.
- `mac_mul_en`, `mac_adder_en`  out  1 each: MAC stage enables.
- `mac_output`  in  16: MAC result.

## Operation
MAC contract:
- Computes `(mux ? mac_output : in_1) * in_2 + in_add`, modulo 2^16.
- Result appears `MAC_LAT` cycles after the issue.
- Holds its value while both enables are low.

Fixed drive values: `mac_mode` = 1 and `mac_adder_input_mux` = 0 at all times.

Coefficient file:
- 8×8 registers, all reset to 0.
- `coef_wr` is honoured only when `busy` = 0; writes while busy are dropped.

FSM states: IDLE, ISSUE, WAIT, CAPTURE, HOLD.
- **IDLE**
  - On `start`, latch `degree` (d) and `x_in`, and assert `busy`.
  - If d = 0, go to CAPTURE. Otherwise go to ISSUE with step k = 0.
  - A `coef_wr` in the same cycle as `start` is visible to the evaluation.
- **ISSUE** (one cycle per step; `mac_mul_en` = `mac_adder_en` = 1)
  - Step 0: `mac_mul_input_mux` = 0, `mac_in_1` = c[d], `mac_in_2` = x, `mac_in_add` = c[d−1].
  - Step k ≥ 1: `mac_mul_input_mux` = 1, `mac_in_2` = x, `mac_in_add` = c[d−1−k].
  - Next state: WAIT if `MAC_LAT` > 1, else continue as below.
  - After the last step (k = d−1), go to CAPTURE. Otherwise increment k and issue the next step.
- **WAIT**
  - Both enables are 0.
  - Stay for `MAC_LAT`−1 cycles, then go to ISSUE for the next step, or to CAPTURE after the last step.
- **CAPTURE**
  - Load `result` from `mac_output`, or from c[0] when d = 0.
  - Pulse `done` and go to HOLD.
- **HOLD**
  - `result_valid` = 1; `result` is stable.
  - On `result_ready`, go to IDLE and drop `busy`.

Input handling:
- `start` is ignored whenever `busy` = 1, including in HOLD on the cycle of the handshake.
- A new `start` can be accepted the cycle after the return to IDLE.

Outside ISSUE, all `mac_in_*`, `mac_mul_input_mux` and both enables are driven to 0.

Reset (at any point, including mid-evaluation):
- State returns to IDLE; the coefficient file and `result` clear.
- `busy`, `done` and `result_valid` are 0.
- The MAC is expected to be reset by the same `reset`.

## Timing
- `start` sampled in cycle S; step k issues in cycle S+1+k·`MAC_LAT`.
- CAPTURE occurs in cycle S+1+d·`MAC_LAT`.
- `result_valid` rises in cycle S+2+d·`MAC_LAT`, coincident with the `done` pulse.
- Example, d = 0: valid at S+2.
- Example, d = 2 with `MAC_LAT` = 1: issues at S+1 and S+2, capture at S+3, valid at S+4.
- Throughput: one evaluation per d·`MAC_LAT`+3 cycles when `result_ready` is tied high.

## Structure
- Package `mac_pkg` holds:
  - FSM state enum;
  - constants `MAC_MODE_TRI` = 1, `MUL_SRC_IN1` = 0, `MUL_SRC_FB` = 1, `ADD_SRC_EXT` = 0;
  - widths `COEF_W` = 8, `ACC_W` = 16.
- Sub-module `mac_coef_rf`: 8×8 register file with async reset, one write port and one combinational read port (plus a second read port for c[d] on step 0).

## Test plan
- Trinomial, `MAC_LAT` = 1: load c2=5, c1=2, c0=1; start with d=2, x=3 → `result` = 52, valid at S+4, and the MAC driven with mux 0 then mux 1.
- Degree 0: c0=77, d=0, any x → `result` = 77 at S+2, with no MAC enable ever asserted.
- Wrap-around: all coefficients 255, d=7, x=255 → `result` = 64512 (0xFC00).
- Backpressure and ignored inputs:
  - Hold `result_ready` low for 5 cycles → `result_valid` and `result` stay stable.
  - `start` and `coef_wr` pulsed while busy are ignored, and the coefficient file is unchanged afterwards.
- `MAC_LAT` = 3, trinomial case:
  - Issues at S+1, S+4; valid at S+8; `result` = 52.
  - Enables low during WAIT.
- Reset asserted during the second ISSUE:
  - All outputs are 0 and the coefficients are cleared.
  - After reloading, a new evaluation gives the correct result.
